// File: rtl/oh_sim_pkg.sv
// rtl/oh_sim_pkg.sv - shared mode encodings, player FSM states and LFSR constants
// Contents:
//   MODE_*        3-bit mode bus encodings shared with the simulation controller
//   state_t       stimulus player FSM states
//   LFSR_SEED     reset value of the random packet generator
//   LFSR_TAPS     Galois feedback mask for x^32+x^22+x^2+x+1
//   lfsr_step()   one right-shift Galois LFSR step
package oh_sim_pkg;

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_LOAD   = 3'd1;
    localparam logic [2:0] MODE_GO     = 3'd2;
    localparam logic [2:0] MODE_RNG    = 3'd3;
    localparam logic [2:0] MODE_BYPASS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DELAY = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/oh_memory_dp.sv
// rtl/oh_memory_dp.sv - DEPTH x DW storage, one sync write port, one sync read port
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address, sampled every clock
//   rd_data  out  registered read data
// Contents are not reset.
module oh_memory_dp #(
    parameter int DW    = 48,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/oh_stimulus.sv
// rtl/oh_stimulus.sv - stimulus player: loads {delay,data} entries, replays them over valid/wait
// Ports:
//   clk          in   clock
//   reset        in   async active-high reset
//   mode         in   0 idle, 1 load, 2 go, 3 rng, 4 bypass, others idle
//   ext_access   in   load/bypass entry valid
//   ext_packet   in   {delay[CW-1:0], data[DW-1:0]}
//   ext_wait     out  pushback to loader
//   stim_access  out  packet valid to DUT
//   stim_packet  out  packet data to DUT
//   stim_wait    in   DUT pushback
//   stim_done    out  playback complete, sticky until reset
// Option macro OH_STIMULUS_RNG_EN: mode rng streams LFSR packets, done after DEPTH transfers.
module oh_stimulus
    import oh_sim_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CW    = 16,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             ext_access,
    input  logic [CW+DW-1:0] ext_packet,
    output logic             ext_wait,
    output logic             stim_access,
    output logic [DW-1:0]    stim_packet,
    input  logic             stim_wait,
    output logic             stim_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW:0]      wr_addr_q, wr_addr_d;
    logic [AW:0]      rd_addr_q, rd_addr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    pkt_q, pkt_d;
    logic             acc_q, acc_d;
    logic             done_q, done_d;
    logic [CW+DW-1:0] rd_data;

    logic is_load, is_go, is_bypass, bypass_on, full, wr_en, xfer, more;

    assign is_load   = (mode == MODE_LOAD);
    assign is_go     = (mode == MODE_GO);
    assign is_bypass = (mode == MODE_BYPASS);
    assign bypass_on = is_bypass & ~reset;
    assign full      = (wr_addr_q == FULL_CNT);
    assign wr_en     = is_load & ext_access & ~full;
    assign xfer      = acc_q & ~stim_wait;
    assign more      = ((rd_addr_q + (AW+1)'(1)) < wr_addr_q);

`ifdef OH_STIMULUS_RNG_EN
    logic [31:0] lfsr_q, lfsr_d;
    logic [AW:0] rng_cnt_q, rng_cnt_d;
    logic        is_rng, rng_on, rng_access;
    logic [DW-1:0] rng_pkt;

    assign is_rng     = (mode == MODE_RNG);
    assign rng_on     = is_rng & ~reset;
    assign rng_access = (rng_cnt_q < FULL_CNT);

    // LFSR word replicated or truncated to the data width
    always_comb begin
        rng_pkt = '0;
        for (int i = 0; i < DW; i++) begin
            rng_pkt[i] = lfsr_q[i % 32];
        end
    end
`endif

    oh_memory_dp #(.DW(CW+DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q[AW-1:0]),
        .wr_data (ext_packet),
        // Read address is the next-state pointer so the entry is ready in FETCH
        .rd_addr (rd_addr_d[AW-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q + (AW+1)'(wr_en);
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        acc_d     = acc_q;
        if (!is_bypass) begin
            if (is_load && state_q != ST_SEND) begin
                state_d   = ST_IDLE;
                rd_addr_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_go) begin
                            if (wr_addr_q == '0) begin
                                state_d = ST_DONE;
                            end else if (rd_addr_q < wr_addr_q) begin
                                state_d = ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        cnt_d = rd_data[CW+DW-1:DW];
                        pkt_d = rd_data[DW-1:0];
                        if (rd_data[CW+DW-1:DW] != '0) begin
                            state_d = ST_DELAY;
                        end else begin
                            state_d = ST_SEND;
                            acc_d   = 1'b1;
                        end
                    end
                    ST_DELAY: begin
                        // Count freezes while mode is away from GO
                        if (is_go) begin
                            if (cnt_q == CW'(1)) begin
                                state_d = ST_SEND;
                                acc_d   = 1'b1;
                            end else begin
                                cnt_d = cnt_q - CW'(1);
                            end
                        end
                    end
                    ST_SEND: begin
                        // Valid is never retracted; a pause takes effect after the transfer
                        if (xfer) begin
                            acc_d     = 1'b0;
                            rd_addr_d = rd_addr_q + (AW+1)'(1);
                            if (!more) begin
                                state_d = ST_DONE;
                            end else if (is_go) begin
                                state_d = ST_FETCH;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    ST_DONE:  state_d = ST_DONE;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
        done_d = done_q | (state_d == ST_DONE);
`ifdef OH_STIMULUS_RNG_EN
        lfsr_d    = lfsr_q;
        rng_cnt_d = rng_cnt_q;
        if (is_rng && rng_access && !stim_wait) begin
            lfsr_d    = lfsr_step(lfsr_q);
            rng_cnt_d = rng_cnt_q + (AW+1)'(1);
        end
        done_d = done_d | (rng_cnt_d == FULL_CNT);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            pkt_q     <= '0;
            acc_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
        end
    end

`ifdef OH_STIMULUS_RNG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= LFSR_SEED;
            rng_cnt_q <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            rng_cnt_q <= rng_cnt_d;
        end
    end
`endif

    // Output steering: bypass is a pure combinational path, otherwise registered playback
    always_comb begin
        stim_access = acc_q;
        stim_packet = pkt_q;
        ext_wait    = 1'b1;
        if (is_load) begin
            ext_wait = full;
        end else if (bypass_on) begin
            stim_access = ext_access;
            stim_packet = ext_packet[DW-1:0];
            ext_wait    = stim_wait;
        end
`ifdef OH_STIMULUS_RNG_EN
        else if (rng_on) begin
            stim_access = rng_access;
            stim_packet = rng_pkt;
        end
`endif
    end

    assign stim_done = done_q;

endmodule

// File: tb/tb_oh_stimulus.sv
// tb/tb_oh_stimulus.sv - scoreboard bench for the oh_stimulus player
module tb_oh_stimulus;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       mode;
    logic             ext_access;
    logic [CW+DW-1:0] ext_packet;
    logic             ext_wait;
    logic             stim_access;
    logic [DW-1:0]    stim_packet;
    logic             stim_wait;
    logic             stim_done;

    oh_stimulus #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .ext_access  (ext_access),
        .ext_packet  (ext_packet),
        .ext_wait    (ext_wait),
        .stim_access (stim_access),
        .stim_packet (stim_packet),
        .stim_wait   (stim_wait),
        .stim_done   (stim_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int go_cyc;
    int ld_cnt;
    logic [DW-1:0] exp_q [$];
    int  xfer_cyc [$];
    bit  done_seen, rise_seen;
    int  done_cyc, rise_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: pops the scoreboard on every accepted packet
    always @(negedge clk) begin
        if (!reset) begin
            if (stim_access && !stim_wait) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("sb_extra_xfer", 1, 0);
                else check("sb_data", stim_packet, exp_q.pop_front());
            end
            if (stim_access && !rise_seen) begin
                rise_seen = 1;
                rise_cyc  = cyc;
            end
            if (stim_done && !done_seen) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        xfer_cyc.delete();
        done_seen = 0;
        rise_seen = 0;
    endtask

    task automatic do_reset();
        reset      = 1;
        mode       = 3'd0;
        ext_access = 0;
        ext_packet = '0;
        stim_wait  = 0;
        repeat (2) tick();
        reset = 0;
        exp_q.delete();
        ld_cnt = 0;
        clear_obs();
        tick();
    endtask

    task automatic load_entry(input logic [CW-1:0] dly, input logic [DW-1:0] dat);
        bit accept;
        accept     = (ld_cnt < DEPTH);
        mode       = 3'd1;
        ext_access = 1;
        ext_packet = {dly, dat};
        #1;
        check("load_ext_wait", ext_wait, !accept);
        if (accept) begin
            exp_q.push_back(dat);
            ld_cnt++;
        end
        @(posedge clk);
        #1;
        ext_access = 0;
    endtask

    task automatic start_go();
        mode   = 3'd2;
        go_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check("done_timeout", done_seen, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_access", stim_access, 0);
        check("rst_packet", stim_packet, 0);
        check("rst_done", stim_done, 0);
        check("rst_ext_wait_idle", ext_wait, 1);

        // Back-to-back zero-delay entries: one transfer every two cycles
        load_entry(0, 32'hAAAA_0001);
        load_entry(0, 32'hBBBB_0002);
        load_entry(0, 32'hCCCC_0003);
        start_go();
        wait_done(40);
        check("t1_xfer_count", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check("t1_first_lat", xfer_cyc[0] - go_cyc, 2);
            check("t1_gap_ab", xfer_cyc[1] - xfer_cyc[0], 2);
            check("t1_gap_bc", xfer_cyc[2] - xfer_cyc[1], 2);
            check("t1_done_lat", done_cyc - xfer_cyc[2], 1);
        end
        check("t1_sb_empty", exp_q.size(), 0);

        // Delay of 5: FETCH, five idle cycles, then SEND
        do_reset();
        load_entry(5, 32'h0000_1234);
        start_go();
        wait_done(40);
        check("t2_rise_lat", rise_cyc - go_cyc, 7);
        check("t2_xfer_count", xfer_cyc.size(), 1);
        check("t2_sb_empty", exp_q.size(), 0);

        // Pushback held for 7 cycles during SEND
        do_reset();
        load_entry(0, 32'hBEEF_0007);
        stim_wait = 1;
        start_go();
        for (int i = 0; i < 20 && !rise_seen; i++) tick();
        check("t3_rise_seen", rise_seen, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t3_hold_access", stim_access, 1);
            check("t3_hold_packet", stim_packet, 32'hBEEF_0007);
        end
        check("t3_no_xfer_while_wait", xfer_cyc.size(), 0);
        stim_wait = 0;
        wait_done(10);
        check("t3_xfer_count", xfer_cyc.size(), 1);

        // Overfill: last two entries dropped, exactly DEPTH transfers
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) load_entry(0, 32'h0100 + 32'(i));
        check("t4_full_wait", ext_wait, 1);
        start_go();
        wait_done(200);
        check("t4_xfer_count", xfer_cyc.size(), DEPTH);
        check("t4_sb_empty", exp_q.size(), 0);

        // GO with nothing loaded
        do_reset();
        start_go();
        tick();
        tick();
        check("t5_done_by_2nd", stim_done, 1);
        check("t5_no_xfer", xfer_cyc.size(), 0);

        // Bypass: combinational pass-through both directions
        do_reset();
        mode       = 3'd4;
        stim_wait  = 1;
        ext_access = 1;
        ext_packet = {16'h0009, 32'hCAFE_0001};
        #1;
        check("byp_ext_wait_hi", ext_wait, 1);
        check("byp_access", stim_access, 1);
        check("byp_packet", stim_packet, 32'hCAFE_0001);
        exp_q.push_back(32'hCAFE_0001);
        stim_wait = 0;
        #1;
        check("byp_ext_wait_lo", ext_wait, 0);
        tick();
        ext_access = 0;
        check("byp_sb_empty", exp_q.size(), 0);
        check("byp_xfer_count", xfer_cyc.size(), 1);

        // Async reset mid-DELAY, then GO with no reload
        do_reset();
        load_entry(20, 32'h0000_0055);
        start_go();
        repeat (5) tick();
        check("t6_in_delay_idle", stim_access, 0);
        #2;
        reset = 1;
        #1;
        check("t6_rst_access", stim_access, 0);
        check("t6_rst_packet", stim_packet, 0);
        check("t6_rst_done", stim_done, 0);
        tick();
        reset = 0;
        exp_q.delete();
        clear_obs();
        start_go();
        wait_done(10);
        check("t6_no_xfer", xfer_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
